// File: rtl/regfile_param.sv
// Register file with 2 combinational read ports, 1 synchronous write port and a CLEAR sweep.
// Latency: reads are combinational. A write is visible the cycle after its edge, or in the same cycle with BYPASS.
// Backpressure: none. Writes that arrive while ClearBusy is high are dropped and flagged on WrDropped.
//
// Ports:
//   clk, reset           : clock; synchronous active-high reset
//   Dest/WriteData/RegWrite : write port
//   Src1/Src2 -> ReadData1/ReadData2 : combinational read ports
//   Clear -> ClearBusy   : starts a DEPTH-cycle zeroing sweep; ClearBusy is high while it runs
//   WrDropped            : one-cycle pulse after a write was discarded by the sweep
module regfile_param #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Dest,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] Src1,
  input  logic [ADDR_W-1:0] Src2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              Clear,
  output logic              ClearBusy,
  output logic              WrDropped
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic busy;
  logic r0_hit;
  logic acc;
  logic drop_req;
  logic byp1;
  logic byp2;

  assign busy      = (state == SWEEP);
  assign ClearBusy = busy;

  // Writes to a hard-wired R0 vanish silently: never stored, never flagged as dropped.
  assign r0_hit   = (ZERO_R0 != 0) && (Dest == '0);
  assign acc      = RegWrite && !reset && !busy && !r0_hit;
  assign drop_req = RegWrite && busy && !r0_hit;

  // acc already excludes reset and the sweep, so the bypass is suppressed in both.
  assign byp1 = (BYPASS != 0) && acc && (Dest == Src1);
  assign byp2 = (BYPASS != 0) && acc && (Dest == Src2);

  assign ReadData1 = ((ZERO_R0 != 0) && (Src1 == '0)) ? '0 :
                     byp1                             ? WriteData : mem[Src1];
  assign ReadData2 = ((ZERO_R0 != 0) && (Src2 == '0)) ? '0 :
                     byp2                             ? WriteData : mem[Src2];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      state     <= IDLE;
      ptr       <= '0;
      WrDropped <= 1'b0;
    end else begin
      WrDropped <= drop_req;
      // acc is never true during SWEEP, so the write and the sweep cannot collide.
      if (acc) begin
        mem[Dest] <= WriteData;
      end
      case (state)
        IDLE: begin
          if (Clear) begin
            state <= SWEEP;
            ptr   <= '0;
          end
        end
        SWEEP: begin
          // Clear is ignored here: the sweep always runs exactly DEPTH cycles.
          mem[ptr] <= '0;
          if (ptr == ADDR_W'(DEPTH - 1)) begin
            state <= IDLE;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three instances (bypass, no bypass, zero-R0 + bypass) share one stimulus.
// Latency: expectations are queued when inputs are driven and compared once the combinational outputs settle.
// Backpressure: none; every wait on the sweep is bounded by a cycle budget.
module tb_regfile_param;

  localparam int NI = 3;
  // Per-instance parameters: 0 = bypass, 1 = no bypass, 2 = zero R0 with bypass.
  localparam int ZR [NI] = '{0, 0, 1};
  localparam int BP [NI] = '{1, 0, 1};

  logic        clk;
  logic        reset;
  logic [3:0]  Dest;
  logic [15:0] WriteData;
  logic        RegWrite;
  logic [3:0]  Src1;
  logic [3:0]  Src2;
  logic        Clear;

  logic [15:0] rd1  [NI];
  logic [15:0] rd2  [NI];
  logic        busy [NI];
  logic        drop [NI];

  regfile_param #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(0), .BYPASS(1)) dut_byp (
    .clk(clk), .reset(reset), .Dest(Dest), .WriteData(WriteData), .RegWrite(RegWrite),
    .Src1(Src1), .Src2(Src2), .ReadData1(rd1[0]), .ReadData2(rd2[0]),
    .Clear(Clear), .ClearBusy(busy[0]), .WrDropped(drop[0]));

  regfile_param #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(0), .BYPASS(0)) dut_nobyp (
    .clk(clk), .reset(reset), .Dest(Dest), .WriteData(WriteData), .RegWrite(RegWrite),
    .Src1(Src1), .Src2(Src2), .ReadData1(rd1[1]), .ReadData2(rd2[1]),
    .Clear(Clear), .ClearBusy(busy[1]), .WrDropped(drop[1]));

  regfile_param #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1), .BYPASS(1)) dut_zr0 (
    .clk(clk), .reset(reset), .Dest(Dest), .WriteData(WriteData), .RegWrite(RegWrite),
    .Src1(Src1), .Src2(Src2), .ReadData1(rd1[2]), .ReadData2(rd2[2]),
    .Clear(Clear), .ClearBusy(busy[2]), .WrDropped(drop[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  logic [15:0] m_mem  [NI][16];
  logic        m_busy;
  logic [3:0]  m_ptr;
  logic        m_drop [NI];

  typedef struct packed {
    logic [NI-1:0][15:0] rd1;
    logic [NI-1:0][15:0] rd2;
    logic                busy;
    logic [NI-1:0]       drop;
  } exp_t;

  exp_t sb [$];

  function automatic logic m_acc(input int i);
    return RegWrite && !reset && !m_busy && !(ZR[i] != 0 && Dest == 4'd0);
  endfunction

  function automatic logic [15:0] m_rd(input int i, input logic [3:0] src);
    if (ZR[i] != 0 && src == 4'd0) return 16'h0;
    if (BP[i] != 0 && m_acc(i) && Dest == src) return WriteData;
    return m_mem[i][src];
  endfunction

  // Apply inputs, queue the expected outputs, then compare once they settle.
  task automatic drive(input logic rst, input logic we, input logic [3:0] d, input logic [15:0] wd,
                       input logic [3:0] a1, input logic [3:0] a2, input logic clr);
    exp_t e;
    exp_t g;
    reset = rst; RegWrite = we; Dest = d; WriteData = wd; Src1 = a1; Src2 = a2; Clear = clr;
    for (int i = 0; i < NI; i++) begin
      e.rd1[i]  = m_rd(i, a1);
      e.rd2[i]  = m_rd(i, a2);
      e.drop[i] = m_drop[i];
    end
    e.busy = m_busy;
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rd1[%0d] src=%0d", i, a1), 32'(rd1[i]), 32'(g.rd1[i]));
      chk($sformatf("rd2[%0d] src=%0d", i, a2), 32'(rd2[i]), 32'(g.rd2[i]));
      chk($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(g.busy));
      chk($sformatf("drop[%0d]", i), 32'(drop[i]), 32'(g.drop[i]));
    end
  endtask

  // Clock edge, then advance the model with the inputs that were sampled.
  task automatic tick();
    logic a [NI];
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NI; i++) begin
        for (int k = 0; k < 16; k++) m_mem[i][k] = 16'h0;
        m_drop[i] = 1'b0;
      end
      m_busy = 1'b0;
      m_ptr  = 4'd0;
    end else begin
      for (int i = 0; i < NI; i++) begin
        a[i] = m_acc(i);
        m_drop[i] = RegWrite && m_busy && !(ZR[i] != 0 && Dest == 4'd0);
        if (a[i]) m_mem[i][Dest] = WriteData;
      end
      if (m_busy) begin
        for (int i = 0; i < NI; i++) m_mem[i][m_ptr] = 16'h0;
        if (m_ptr == 4'd15) m_busy = 1'b0;
        else m_ptr = m_ptr + 4'd1;
      end else if (Clear) begin
        m_busy = 1'b1;
        m_ptr  = 4'd0;
      end
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    logic [3:0] a;

    reset = 1'b1; RegWrite = 1'b0; Dest = '0; WriteData = '0; Src1 = '0; Src2 = '0; Clear = 1'b0;
    tick();

    // Reset state: every entry reads zero, no busy, no drop.
    for (int k = 0; k < 16; k++) begin
      a = 4'(k);
      drive(0, 0, 0, 16'h0, a, ~a, 0);
      chk("rst_rd1", 32'(rd1[0]), 32'h0);
      chk("rst_busy", 32'(busy[0]), 32'h0);
      tick();
    end

    // Write R3 then read it; bypass shows it in the same cycle only on bypass instances.
    drive(0, 1, 3, 16'hBEEF, 3, 3, 0);
    chk("byp_same_r3", 32'(rd1[0]), 32'hBEEF);
    chk("nobyp_same_r3", 32'(rd1[1]), 32'h0);
    tick();
    drive(0, 0, 0, 16'h0, 3, 0, 0);
    chk("nobyp_next_r3", 32'(rd1[1]), 32'hBEEF);
    tick();

    drive(0, 1, 5, 16'h1234, 0, 5, 0);
    chk("byp_same_r5", 32'(rd2[0]), 32'h1234);
    chk("nobyp_same_r5", 32'(rd2[1]), 32'h0);
    tick();
    drive(0, 0, 0, 16'h0, 3, 5, 0);
    chk("nobyp_next_r5", 32'(rd2[1]), 32'h1234);
    tick();

    // R0 write: ordinary on instances 0/1, ignored on the zero-R0 instance.
    drive(0, 1, 0, 16'hFFFF, 0, 0, 0);
    chk("zr0_byp_r0", 32'(rd1[2]), 32'h0);
    chk("plain_byp_r0", 32'(rd1[0]), 32'hFFFF);
    tick();
    drive(0, 0, 0, 16'h0, 0, 0, 0);
    chk("zr0_r0", 32'(rd1[2]), 32'h0);
    chk("zr0_nodrop", 32'(drop[2]), 32'h0);
    tick();

    // Fill every entry with index*0x1111.
    for (int k = 0; k < 16; k++) begin
      a = 4'(k);
      drive(0, 1, a, 16'(k * 16'h1111), a, 4'(k + 1), 0);
      tick();
    end

    // Sweep: count busy cycles, drop a write, re-assert Clear midway.
    drive(0, 0, 0, 16'h0, 0, 0, 1);
    tick();
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 3)       drive(0, 1, 7, 16'hAAAA, 7, 6, 1);
      else if (c == 4)  drive(0, 0, 0, 16'h0, 7, 3, 0);
      else if (c == 6)  drive(0, 0, 0, 16'h0, 5, 6, 0);
      else if (c == 10) drive(0, 0, 0, 16'h0, 12, 9, 1);
      else              drive(0, 0, 0, 16'h0, 4'(c), 15, 0);
      if (c == 4) begin
        chk("sweep_r7_kept", 32'(rd1[0]), 32'h7777);
        chk("sweep_drop", 32'(drop[0]), 32'h1);
      end
      if (c == 6) begin
        chk("sweep_r5_cleared", 32'(rd1[0]), 32'h0);
        chk("sweep_r6_kept", 32'(rd2[0]), 32'h6666);
      end
      if (busy[0] !== 1'b1) break;
      busy_cnt++;
      tick();
    end
    chk("busy_cycles", 32'(busy_cnt), 32'd16);
    tick();

    for (int k = 0; k < 16; k++) begin
      a = 4'(k);
      drive(0, 0, 0, 16'h0, a, a, 0);
      chk("post_sweep_zero", 32'(rd1[0]), 32'h0);
      tick();
    end

    // First write after the sweep is accepted.
    drive(0, 1, 9, 16'h5A5A, 9, 9, 0);
    tick();
    drive(0, 0, 0, 16'h0, 9, 1, 0);
    chk("post_sweep_wr", 32'(rd1[1]), 32'h5A5A);
    tick();

    // Reset aborts a sweep at cycle 4; no bypass during the reset cycle.
    drive(0, 0, 0, 16'h0, 0, 0, 1);
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 0, 16'h0, 4'(c), 9, 0);
      tick();
    end
    drive(1, 1, 9, 16'h2222, 9, 9, 1);
    chk("rst_cycle_nobyp", 32'(rd1[0]), 32'h5A5A);
    tick();
    drive(0, 0, 0, 16'h0, 9, 9, 0);
    chk("rst_abort_busy", 32'(busy[0]), 32'h0);
    chk("rst_abort_r9", 32'(rd1[0]), 32'h0);
    tick();
    for (int k = 0; k < 16; k++) begin
      a = 4'(k);
      drive(0, 0, 0, 16'h0, a, ~a, 0);
      tick();
    end

    // Write right after reset is accepted normally.
    drive(0, 1, 4, 16'h4444, 4, 4, 0);
    tick();
    drive(0, 0, 0, 16'h0, 4, 4, 0);
    chk("after_rst_wr", 32'(rd1[1]), 32'h4444);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
